// File: rtl/nbyte_memory.sv
// nbyte_memory: DEPTH x WIDTH word memory with registered read, read-valid strobe and a
// self-sequenced clear engine. Define NBYTE_MEMORY_TRISTATE_EN to tri-state data_out when idle.
module nbyte_memory #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clr,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]    dout_q, dout_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [WIDTH-1:0]    mem_wdata_s;
    logic                addr_ok_s;

    assign addr_ok_s = ({1'b0, addr} < DEPTH_L);

    // State and read-path registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= {ADDR_W{1'b0}};
            rd_valid_q <= 1'b0;
            dout_q     <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_valid_q <= rd_valid_d;
            dout_q     <= dout_d;
        end
    end

    // Storage array; contents are zeroed by the clear engine rather than by reset
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Datapath control: clear sweep, writes and reads; clr outranks any request
    always_comb begin
        clr_ptr_d   = clr_ptr_q;
        rd_valid_d  = 1'b0;
        dout_d      = dout_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = addr;
        mem_wdata_s = data_in;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = {WIDTH{1'b0}};
                clr_ptr_d   = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            ST_IDLE: begin
                if (clr) begin
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else if (cs && wr) begin
                    mem_we_s = addr_ok_s;
                end else if (cs) begin
                    rd_valid_d = 1'b1;
                    if (addr_ok_s) begin
                        dout_d = mem_q[addr];
                    end else begin
                        dout_d = {WIDTH{1'b0}};
                    end
                end else begin
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign rd_valid = rd_valid_q;

`ifdef NBYTE_MEMORY_TRISTATE_EN
    assign data_out = rd_valid_q ? dout_q : {WIDTH{1'bz}};
`else
    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_nbyte_memory.sv
// Directed self-checking bench for nbyte_memory (WIDTH=8, DEPTH=4, ADDR_W=2).
module tb_nbyte_memory;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic       clr;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       busy;

    int n_checks;
    int n_fail;

    nbyte_memory #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .clr      (clr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // data_out when no read result is being presented
    task automatic check_idle_dout(input string tag, input logic [7:0] held);
`ifdef NBYTE_MEMORY_TRISTATE_EN
        check(tag, {24'h0, data_out}, {24'h0, 8'bzzzzzzzz});
`else
        check(tag, {24'h0, data_out}, {24'h0, held});
`endif
    endtask

    task automatic set_req(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
        cs      = c;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        clr = 1'b0;
        set_req(1'b0, 1'b0, 2'd0, 8'h00);

        // Reset held two cycles
        step();
        step();
        check("rst_busy", {31'h0, busy}, 32'd1);
        check("rst_rdv", {31'h0, rd_valid}, 32'd0);
        check_idle_dout("rst_dout", 8'h00);

        // Busy for exactly four cycles after release
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("clr_busy_%0d", i), {31'h0, busy}, 32'd1);
        end
        step();
        check("clr_done", {31'h0, busy}, 32'd0);

        // Back-to-back reads of the cleared array
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 2'(i), 8'h00);
            step();
            check($sformatf("init_rdv_%0d", i), {31'h0, rd_valid}, 32'd1);
            check($sformatf("init_rd_%0d", i), {24'h0, data_out}, 32'h00);
        end
        set_req(1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("init_rdv_end", {31'h0, rd_valid}, 32'd0);

        // Write 0xA5@1, 0x3C@2, then read both consecutively
        set_req(1'b1, 1'b1, 2'd1, 8'hA5);
        step();
        check("wr1_rdv", {31'h0, rd_valid}, 32'd0);
        set_req(1'b1, 1'b1, 2'd2, 8'h3C);
        step();
        check("wr2_rdv", {31'h0, rd_valid}, 32'd0);
        set_req(1'b1, 1'b0, 2'd1, 8'h00);
        step();
        check("rd1_rdv", {31'h0, rd_valid}, 32'd1);
        check("rd1_data", {24'h0, data_out}, 32'hA5);
        set_req(1'b1, 1'b0, 2'd2, 8'h00);
        step();
        check("rd2_rdv", {31'h0, rd_valid}, 32'd1);
        check("rd2_data", {24'h0, data_out}, 32'h3C);
        set_req(1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("rd_end_rdv", {31'h0, rd_valid}, 32'd0);
        check_idle_dout("rd_end_hold", 8'h3C);

        // Write then immediate read of the same word
        set_req(1'b1, 1'b1, 2'd3, 8'h5A);
        step();
        set_req(1'b1, 1'b0, 2'd3, 8'h00);
        step();
        check("wtr_rdv", {31'h0, rd_valid}, 32'd1);
        check("wtr_data", {24'h0, data_out}, 32'h5A);

        // clr outranks a simultaneous write; requests during busy are dropped
        clr = 1'b1;
        set_req(1'b1, 1'b1, 2'd0, 8'hFF);
        step();
        check("cp_busy_0", {31'h0, busy}, 32'd1);
        check("cp_rdv_0", {31'h0, rd_valid}, 32'd0);
        clr = 1'b0;
        set_req(1'b1, 1'b0, 2'd1, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            clr = (i == 2) ? 1'b1 : 1'b0;
            step();
            check($sformatf("cp_busy_%0d", i), {31'h0, busy}, 32'd1);
            check($sformatf("cp_rdv_%0d", i), {31'h0, rd_valid}, 32'd0);
            check_idle_dout($sformatf("cp_hold_%0d", i), 8'h5A);
        end
        clr = 1'b0;
        step();
        check("cp_done", {31'h0, busy}, 32'd0);
        check("cp_rdv_4", {31'h0, rd_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 2'(i), 8'h00);
            step();
            check($sformatf("cp_rdv_rd_%0d", i), {31'h0, rd_valid}, 32'd1);
            check($sformatf("cp_rd_%0d", i), {24'h0, data_out}, 32'h00);
        end

        // Put data in word 2, then reset during the second clear cycle
        set_req(1'b1, 1'b1, 2'd2, 8'h77);
        step();
        set_req(1'b0, 1'b0, 2'd0, 8'h00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rmc_busy_0", {31'h0, busy}, 32'd1);
        check("rmc_rdv_0", {31'h0, rd_valid}, 32'd0);
        check_idle_dout("rmc_dout", 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("rmc_busy_%0d", i), {31'h0, busy}, 32'd1);
        end
        step();
        check("rmc_done", {31'h0, busy}, 32'd0);
        set_req(1'b1, 1'b0, 2'd2, 8'h00);
        step();
        check("rmc_rdv", {31'h0, rd_valid}, 32'd1);
        check("rmc_rd2", {24'h0, data_out}, 32'h00);
        set_req(1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("final_rdv", {31'h0, rd_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
